// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised, majority-voted line sampling with a
// valid/ready holding register and parity/framing/overrun reporting.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_rx_uart,
    input  logic                 i_rx_ready,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_d;
    logic [1:0]           sync_q;
    logic [2:0]           hist;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 perr, perr_d;
    logic                 ferr, ferr_d;
    logic                 armed, armed_d;
    logic                 dv_d, pe_d, fe_d, ov_d;
    logic [DATA_BITS-1:0] byte_d;
    logic                 line;
    logic                 maj;
    logic                 bit_end;
    logic                 deliver;
    logic                 ferr_now;

    assign line    = sync_q[1];
    assign maj     = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Input synchroniser and 3-sample history, preset to idle-high
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 2'b11;
            hist   <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], i_rx_uart};
            hist   <= {hist[1:0], sync_q[1]};
        end
    end

    // State, datapath and output holding register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            armed        <= 1'b0;
            o_rx_dv      <= 1'b0;
            o_rx_byte    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            shreg        <= shreg_d;
            perr         <= perr_d;
            ferr         <= ferr_d;
            armed        <= armed_d;
            o_rx_dv      <= dv_d;
            o_rx_byte    <= byte_d;
            o_parity_err <= pe_d;
            o_frame_err  <= fe_d;
            o_overrun    <= ov_d;
            o_busy       <= (state_d != S_IDLE);
        end
    end

    // Next-state, bit decisions and delivery/handshake
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        shreg_d  = shreg;
        perr_d   = perr;
        ferr_d   = ferr;
        armed_d  = armed;
        dv_d     = o_rx_dv;
        byte_d   = o_rx_byte;
        pe_d     = o_parity_err;
        fe_d     = o_frame_err;
        ov_d     = 1'b0;
        deliver  = 1'b0;
        ferr_now = ferr;

        case (state)
            S_IDLE: begin
                cnt_d   = '0;
                armed_d = armed | line;
                // Only a high-to-low transition after a seen idle level starts a frame
                if (armed && !line) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt == CNT_W'(HALF)) begin
                    cnt_d = '0;
                    if (!maj) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {maj, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_STOP;
                    perr_d  = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    ferr_now = ferr | ~maj;
                    ferr_d   = ferr_now;
                    // Return to idle mid-stop-bit so the next start edge is caught promptly
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        deliver = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (deliver) begin
            if (!o_rx_dv || i_rx_ready) begin
                dv_d   = 1'b1;
                byte_d = shreg;
                pe_d   = perr;
                fe_d   = ferr_now;
            end else begin
                ov_d = 1'b1;
            end
        end else if (o_rx_dv && i_rx_ready) begin
            dv_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int unsigned CPB_A = 217;
    localparam int unsigned CPB_B = 24;
    localparam int unsigned CPB_C = 20;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       dv_a, dv_b, dv_c;
    logic [7:0] byte_a, byte_b;
    logic [6:0] byte_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       ov_a, ov_b, ov_c;
    logic       busy_a, busy_b, busy_c;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt_a = 0;
    rec_t q_a[$], q_b[$], q_c[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_uart(rx_a), .i_rx_ready(rdy_a),
        .o_rx_dv(dv_a), .o_rx_byte(byte_a), .o_parity_err(pe_a), .o_frame_err(fe_a),
        .o_overrun(ov_a), .o_busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_uart(rx_b), .i_rx_ready(rdy_b),
        .o_rx_dv(dv_b), .o_rx_byte(byte_b), .o_parity_err(pe_b), .o_frame_err(fe_b),
        .o_overrun(ov_b), .o_busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_uart(rx_c), .i_rx_ready(rdy_c),
        .o_rx_dv(dv_c), .o_rx_byte(byte_c), .o_parity_err(pe_c), .o_frame_err(fe_c),
        .o_overrun(ov_c), .o_busy(busy_c));

    // Record every accepted holding-register transfer and count overrun cycles
    always @(negedge clk) begin
        if (dv_a && rdy_a) q_a.push_back('{9'(byte_a), pe_a, fe_a});
        if (dv_b && rdy_b) q_b.push_back('{9'(byte_b), pe_b, fe_b});
        if (dv_c && rdy_c) q_c.push_back('{9'(byte_c), pe_c, fe_c});
        if (ov_a) ov_cnt_a = ov_cnt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input int n);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input int cpb, input int nbits,
                              input logic [8:0] data, input bit has_par, input logic par_bit,
                              input int nstop, input logic [1:0] stops);
        drive(which, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive(which, data[i], cpb);
        if (has_par) drive(which, par_bit, cpb);
        for (int s = 0; s < nstop; s++) drive(which, stops[s], cpb);
    endtask

    // Reference: even parity is violated when the total count of ones is odd
    function automatic logic exp_perr_even(input logic [8:0] data, input logic par_bit);
        return 1'(($countones(data) + int'(par_bit)) % 2);
    endfunction

    task automatic pop_chk(input int which, input string tag,
                           input logic [8:0] eb, input logic ep, input logic ef);
        rec_t r;
        int   sz;
        case (which)
            0:       sz = q_a.size();
            1:       sz = q_b.size();
            default: sz = q_c.size();
        endcase
        if (sz == 0) begin
            chk({tag, "_delivered"}, 32'd0, 32'd1);
        end else begin
            case (which)
                0:       r = q_a.pop_front();
                1:       r = q_b.pop_front();
                default: r = q_c.pop_front();
            endcase
            chk({tag, "_byte"}, 32'(r.data), 32'(eb));
            chk({tag, "_perr"}, 32'(r.pe), 32'(ep));
            chk({tag, "_ferr"}, 32'(r.fe), 32'(ef));
        end
    endtask

    initial begin
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;

        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        #1;
        chk("reset_dv",   32'(dv_a),   32'd0);
        chk("reset_byte", 32'(byte_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_ov",   32'(ov_a),   32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 10);

        // 8N1 single frame with consumer always ready
        send_frame(0, CPB_A, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, 2 * CPB_A);
        chk("t1_one_pulse", 32'(q_a.size()), 32'd1);
        pop_chk(0, "t1", 9'h0A5, 1'b0, 1'b0);

        // 8N1 random bytes
        for (int k = 0; k < 5; k++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, CPB_A, 8, d, 1'b0, 1'b0, 1, 2'b11);
            drive(0, 1'b1, CPB_A + $urandom_range(0, 40));
            pop_chk(0, "a_rand", d, 1'b0, 1'b0);
        end

        // Short low glitch from idle must be rejected
        drive(0, 1'b0, 50);
        drive(0, 1'b1, 10);
        chk("t3_busy_during", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 300);
        chk("t3_busy_after", 32'(busy_a), 32'd0);
        chk("t3_dv_after",   32'(dv_a),   32'd0);
        chk("t3_no_frame",   32'(q_a.size()), 32'd0);

        // 8E1: wrong then correct parity bit for 0x03
        send_frame(1, CPB_B, 8, 9'h003, 1'b1, 1'b1, 1, 2'b11);
        drive(1, 1'b1, 2 * CPB_B);
        pop_chk(1, "t2_bad_par", 9'h003, 1'b1, 1'b0);
        send_frame(1, CPB_B, 8, 9'h003, 1'b1, 1'b0, 1, 2'b11);
        drive(1, 1'b1, 2 * CPB_B);
        pop_chk(1, "t2_good_par", 9'h003, 1'b0, 1'b0);

        // 8E1 random data, parity bit and stop bit
        for (int k = 0; k < 8; k++) begin
            d  = 9'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            send_frame(1, CPB_B, 8, d, 1'b1, pb, 1, st);
            drive(1, 1'b1, 2 * CPB_B);
            pop_chk(1, "b_rand", d, exp_perr_even(d, pb), ~st[0]);
        end

        // 7N2 with second stop bit low, then line held low (break)
        send_frame(2, CPB_C, 7, 9'h055, 1'b0, 1'b0, 2, 2'b01);
        drive(2, 1'b0, 5 * CPB_C);
        pop_chk(2, "t4_ferr", 9'h055, 1'b0, 1'b1);
        chk("t4_no_retrigger", 32'(q_c.size()), 32'd0);
        chk("t4_busy_break",   32'(busy_c),     32'd0);
        drive(2, 1'b1, 2 * CPB_C);
        send_frame(2, CPB_C, 7, 9'h02B, 1'b0, 1'b0, 2, 2'b11);
        drive(2, 1'b1, 2 * CPB_C);
        pop_chk(2, "t4_recover", 9'h02B, 1'b0, 1'b0);

        // 7N2 random data and stop bits
        for (int k = 0; k < 8; k++) begin
            d  = 9'($urandom_range(0, 127));
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(2, CPB_C, 7, d, 1'b0, 1'b0, 2, st);
            drive(2, 1'b1, 2 * CPB_C);
            pop_chk(2, "c_rand", d, 1'b0, ~(st[0] & st[1]));
        end

        // Consumer stalled: second frame is dropped with a one-cycle overrun
        rdy_a = 1'b0;
        ov_cnt_a = 0;
        send_frame(0, CPB_A, 8, 9'h011, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, CPB_A);
        send_frame(0, CPB_A, 8, 9'h022, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, CPB_A);
        chk("t5_dv_held",  32'(dv_a),     32'd1);
        chk("t5_byte_kept", 32'(byte_a),  32'h11);
        chk("t5_ov_pulse", 32'(ov_cnt_a), 32'd1);
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        chk("t5_dv_clear", 32'(dv_a), 32'd0);
        pop_chk(0, "t5_accept", 9'h011, 1'b0, 1'b0);
        chk("t5_single", 32'(q_a.size()), 32'd0);

        // Reset in the middle of data bit 4, then a clean frame
        drive(0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, CPB_A);
        drive(0, 1'b0, CPB_A / 2);
        chk("t6_busy_before", 32'(busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy_rst", 32'(busy_a), 32'd0);
        chk("t6_byte_rst", 32'(byte_a), 32'd0);
        chk("t6_dv_rst",   32'(dv_a),   32'd0);
        repeat (3) @(posedge clk);
        rx_a = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 20);
        send_frame(0, CPB_A, 8, 9'h05A, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, 2 * CPB_A);
        pop_chk(0, "t6_after", 9'h05A, 1'b0, 1'b0);
        chk("t6_single", 32'(q_a.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
